// File: rtl/sd_cmd_if.sv
// sd_cmd_if: host/physical-layer signals of one SD command transaction.
interface sd_cmd_if #(parameter int RESP_W = 48);
  logic              new_cmd;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_argument;
  logic              resp_expected;
  logic              serial_ready;
  logic              ack_in;
  logic              strobe_in;
  logic [RESP_W-1:0] response_in;
  logic [39:0]       cmd_out;
  logic              strobe_out;
  logic              ack_out;
  logic [RESP_W-1:0] response;
  logic              busy;
  logic              cmd_complete;
  logic              timeout_error;
  modport slave (
    input  new_cmd, cmd_index, cmd_argument, resp_expected, serial_ready, ack_in, strobe_in, response_in,
    output cmd_out, strobe_out, ack_out, response, busy, cmd_complete, timeout_error
  );
  modport master (
    output new_cmd, cmd_index, cmd_argument, resp_expected, serial_ready, ack_in, strobe_in, response_in,
    input  cmd_out, strobe_out, ack_out, response, busy, cmd_complete, timeout_error
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: sequences one SD command frame hand-off and its response/timeout.
module sd_cmd_sequencer #(
  parameter int RESP_W    = 48,
  parameter int TIMEOUT   = 1024,
  parameter int TIMEOUT_W = 16
) (
  input logic     clock,
  input logic     reset,
  sd_cmd_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_READY, SEND, WAIT_RESP, ACK_RESP, DONE} state_t;
  state_t state, state_n;
  logic resp_exp;
  logic [TIMEOUT_W-1:0] cnt;
  logic hit;
  logic capture;
  assign hit = cnt == TIMEOUT_W'(TIMEOUT - 1);
  assign capture = state == IDLE && bus.new_cmd;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = bus.new_cmd ? WAIT_READY : IDLE;
      WAIT_READY: state_n = bus.serial_ready ? SEND : WAIT_READY;
      SEND:       state_n = !bus.ack_in ? SEND : resp_exp ? WAIT_RESP : DONE;
      WAIT_RESP:  state_n = bus.strobe_in ? ACK_RESP : hit ? DONE : WAIT_RESP;
      ACK_RESP:   state_n = bus.strobe_in ? ACK_RESP : DONE;
      DONE:       state_n = bus.new_cmd ? DONE : IDLE;
      default:    state_n = IDLE;
    endcase
  end
  // Handshake/status outputs are registered images of the state being entered.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state             <= IDLE;
      resp_exp          <= 1'b0;
      cnt               <= '0;
      bus.cmd_out       <= '0;
      bus.strobe_out    <= 1'b0;
      bus.ack_out       <= 1'b0;
      bus.response      <= '0;
      bus.busy          <= 1'b0;
      bus.cmd_complete  <= 1'b0;
      bus.timeout_error <= 1'b0;
    end else begin
      state            <= state_n;
      bus.strobe_out   <= state_n == SEND;
      bus.ack_out      <= state_n == ACK_RESP;
      bus.busy         <= state_n != IDLE;
      bus.cmd_complete <= state_n == DONE;
      cnt              <= state != WAIT_RESP ? '0 : hit ? cnt : cnt + TIMEOUT_W'(1);
      if (capture) begin
        bus.cmd_out       <= {2'b01, bus.cmd_index, bus.cmd_argument};
        resp_exp          <= bus.resp_expected;
        bus.response      <= '0;
        bus.timeout_error <= 1'b0;
      end
      if (state == WAIT_RESP && bus.strobe_in) bus.response <= bus.response_in;
      if (state == WAIT_RESP && !bus.strobe_in && hit) bus.timeout_error <= 1'b1;
    end
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed transactions checked against an interval-based timeline model.
module tb_sd_cmd_sequencer;
  localparam int RESP_W = 48;
  localparam int TO = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic exp_busy, exp_strobe, exp_ack, exp_cc, exp_to;
  logic [RESP_W-1:0] exp_resp;
  logic [39:0] exp_cmd;
  int kcur = 0;
  int first_to = -1;
  int st_cnt = 0;
  sd_cmd_if #(.RESP_W(RESP_W)) bus();
  sd_cmd_sequencer #(.RESP_W(RESP_W), .TIMEOUT(TO), .TIMEOUT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clock) if (chk_en) begin
    check("busy", 64'(bus.busy), 64'(exp_busy));
    check("strobe_out", 64'(bus.strobe_out), 64'(exp_strobe));
    check("ack_out", 64'(bus.ack_out), 64'(exp_ack));
    check("cmd_complete", 64'(bus.cmd_complete), 64'(exp_cc));
    check("timeout_error", 64'(bus.timeout_error), 64'(exp_to));
    check("response", 64'(bus.response), 64'(exp_resp));
    check("cmd_out", 64'(bus.cmd_out), 64'(exp_cmd));
    if (bus.strobe_out) st_cnt++;
    if (bus.timeout_error && first_to < 0) first_to = kcur;
  end
  // Edge 0 is the capture edge; s/a/r/d/e are the edges where strobe rises, ack is seen,
  // response strobe is seen, DONE is entered and IDLE is re-entered.
  task automatic run(input logic [5:0] idx, input logic [31:0] arg, input logic resp,
                     input int rd, input int ad, input int sd, input int sl, input int hd,
                     input logic [RESP_W-1:0] val, input logic toggle, input logic noise);
    int s, a, r, d, e;
    logic to, real_strobe;
    s = 1 + rd;
    a = s + ad;
    to = resp && sd >= TO;
    r = a + 1 + sd;
    d = !resp ? a : to ? a + TO : r + sl;
    e = d + hd;
    st_cnt = 0;
    first_to = -1;
    for (int j = 0; j <= e + 2; j++) begin
      real_strobe = resp && !to && j >= r && j < r + sl;
      bus.new_cmd = j < e && !(toggle && (j == 3 || j == 4));
      bus.cmd_index = j == 0 ? idx : ~idx;
      bus.cmd_argument = j == 0 ? arg : ~arg;
      bus.resp_expected = j == 0 ? resp : !resp;
      bus.serial_ready = rd == 0 || j >= s;
      bus.ack_in = j == a || (noise && j < s);
      bus.strobe_in = real_strobe || (noise && j < s);
      bus.response_in = real_strobe ? val : 48'hBAD0BAD0BAD0;
      @(posedge clock);
      #1;
      kcur = j;
      exp_busy = j < e;
      exp_strobe = j >= s && j < a;
      exp_ack = resp && !to && j >= r && j < d;
      exp_cc = j >= d && j < e;
      exp_to = to && j >= d;
      exp_resp = (resp && !to && j >= r) ? val : '0;
      exp_cmd = {2'b01, idx, arg};
      chk_en = 1'b1;
    end
    bus.ack_in = 1'b0;
    bus.strobe_in = 1'b0;
  endtask
  initial begin
    bus.new_cmd = 0; bus.cmd_index = 0; bus.cmd_argument = 0; bus.resp_expected = 0;
    bus.serial_ready = 0; bus.ack_in = 0; bus.strobe_in = 0; bus.response_in = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_strobe", 64'(bus.strobe_out), 64'd0);
    check("rst_ack", 64'(bus.ack_out), 64'd0);
    check("rst_cc", 64'(bus.cmd_complete), 64'd0);
    check("rst_to", 64'(bus.timeout_error), 64'd0);
    check("rst_resp", 64'(bus.response), 64'd0);
    check("rst_cmd", 64'(bus.cmd_out), 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    run(6'd0, 32'h0, 1'b0, 0, 5, 0, 0, 3, '0, 1'b0, 1'b0);
    check("t2_strobe_len", 64'(st_cnt), 64'd5);
    check("t2_cmd_lit", 64'(bus.cmd_out), 64'h4000000000);
    check("t2_to_lit", 64'(bus.timeout_error), 64'd0);
    run(6'd8, 32'h000001AA, 1'b1, 0, 3, 2, 3, 2, 48'h08000001AA87, 1'b0, 1'b0);
    check("t3_cmd_lit", 64'(bus.cmd_out), 64'h48000001AA);
    check("t3_resp_lit", 64'(bus.response), 64'h08000001AA87);
    run(6'd1, 32'h12345678, 1'b1, 0, 5, 1000, 0, 2, '0, 1'b0, 1'b0);
    check("t4_to_edge_lit", 64'(first_to), 64'd22);
    check("t4_to_lit", 64'(bus.timeout_error), 64'd1);
    check("t4_resp_lit", 64'(bus.response), 64'd0);
    run(6'd2, 32'hCAFEF00D, 1'b1, 0, 2, TO - 1, 1, 2, 48'h123456789ABC, 1'b0, 1'b0);
    check("bnd_to_lit", 64'(bus.timeout_error), 64'd0);
    check("bnd_resp_lit", 64'(bus.response), 64'h123456789ABC);
    run(6'd55, 32'hFFFFFFFF, 1'b1, 20, 2, 0, 1, 4, 48'hA5A5A5A5A5A5, 1'b1, 1'b1);
    check("t5_strobe_len", 64'(st_cnt), 64'd2);
    check("t5_cmd_lit", 64'(bus.cmd_out), 64'h77FFFFFFFF);
    chk_en = 1'b0;
    bus.new_cmd = 1; bus.cmd_index = 6'd9; bus.cmd_argument = 32'h55; bus.resp_expected = 0;
    bus.serial_ready = 1; bus.ack_in = 0; bus.strobe_in = 0;
    repeat (2) @(posedge clock);
    #1;
    check("pre_abort_strobe", 64'(bus.strobe_out), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_strobe", 64'(bus.strobe_out), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_cmd", 64'(bus.cmd_out), 64'd0);
    bus.new_cmd = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_abort_busy", 64'(bus.busy), 64'd0);
    run(6'd3, 32'h0BADBEEF, 1'b0, 0, 1, 0, 0, 1, '0, 1'b0, 1'b0);
    check("t6_cmd_lit", 64'(bus.cmd_out), 64'h430BADBEEF);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
